// File: rtl/wave_capture.sv
// ============================================================================
// Module      : wave_capture
// Description : Zero-crossing triggered waveform capture for the scope path.
//               Arms on a positive-going zero crossing (or a free-run timeout)
//               and writes 256 display-scaled samples into the inactive half
//               of a double-buffered sample RAM. The halves flip once the
//               display reports idle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wave_capture #(
  parameter int AUTO_TRIG = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        new_sample_ready,
  input  logic [15:0] new_sample_in,
  input  logic        wave_display_idle,
  output logic [8:0]  write_address,
  output logic        write_enable,
  output logic [7:0]  write_sample,
  output logic        read_index,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    S_ARMED  = 2'd0,
    S_ACTIVE = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  // A zero AUTO_TRIG turns the free-run timeout off entirely.
  localparam bit          AUTO_EN   = (AUTO_TRIG != 0);
  localparam logic [15:0] TRIG_LAST = AUTO_EN ? 16'(AUTO_TRIG - 1) : 16'd0;

  state_t      state_q;
  logic        read_index_q;
  logic        write_enable_q;
  logic [8:0]  write_address_q;
  logic [7:0]  write_sample_q;
  logic        frame_done_q;
  logic        prev_msb_q;
  logic [7:0]  offset_q;
  logic [15:0] tcnt_q;

  logic [7:0]  scaled;
  logic        zero_cross;
  logic        timeout_hit;
  logic [7:0]  offset_d;
  logic        unused_low_bits;

  // Sign bit kept, magnitude bits inverted: +127 lands at the top row (0),
  // zero mid-screen (127) and -128 at the bottom row (255).
  assign scaled      = {new_sample_in[15], ~new_sample_in[14:8]};
  assign zero_cross  = prev_msb_q & ~new_sample_in[15];
  assign timeout_hit = AUTO_EN && (tcnt_q == TRIG_LAST);
  assign offset_d    = offset_q + 8'd1;

  // Only the top byte of the sample reaches the display.
  assign unused_low_bits = ^new_sample_in[7:0];

  // Capture FSM with registered RAM write port and frame flip.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_ARMED;
      read_index_q    <= 1'b0;
      write_enable_q  <= 1'b0;
      write_address_q <= 9'd0;
      write_sample_q  <= 8'd0;
      frame_done_q    <= 1'b0;
      prev_msb_q      <= 1'b0;
      offset_q        <= 8'd0;
      tcnt_q          <= 16'd0;
    end else begin
      write_enable_q <= 1'b0;
      frame_done_q   <= 1'b0;

      // Crossing detection looks at every strobe regardless of state.
      if (new_sample_ready) begin
        prev_msb_q <= new_sample_in[15];
      end

      case (state_q)
        S_ARMED: begin
          if (new_sample_ready) begin
            if (zero_cross || timeout_hit) begin
              // Triggering sample is the first point of the frame.
              write_enable_q  <= 1'b1;
              write_address_q <= {~read_index_q, 8'd0};
              write_sample_q  <= scaled;
              offset_q        <= 8'd1;
              tcnt_q          <= 16'd0;
              state_q         <= S_ACTIVE;
            end else begin
              tcnt_q <= tcnt_q + 16'd1;
            end
          end
        end

        S_ACTIVE: begin
          if (new_sample_ready) begin
            write_enable_q  <= 1'b1;
            write_address_q <= {~read_index_q, offset_q};
            write_sample_q  <= scaled;
            offset_q        <= offset_d;
            if (offset_q == 8'hFF) begin
              state_q <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          // Flip only while the display is off the waveform region so it
          // never shows a torn frame.
          if (wave_display_idle) begin
            read_index_q <= ~read_index_q;
            frame_done_q <= 1'b1;
            state_q      <= S_ARMED;
          end
        end

        default: begin
          state_q <= S_ARMED;
        end
      endcase
    end
  end

  assign write_address = write_address_q;
  assign write_enable  = write_enable_q;
  assign write_sample  = write_sample_q;
  assign read_index    = read_index_q;
  assign frame_done    = frame_done_q;

endmodule

`default_nettype wire
